muldiv_dispatch_queue: RTL and testbench
========================================

Name: muldiv_dispatch_queue

Overview:
- In-order request FIFO directly upstream of the integer MUL/DIV unit.
- Decouples the issue stage from the unit's variable acceptance: serial divide backpressure and the MUL-priority output stall.
- Reports per-warp pending status so the scheduler can see which warps hold queued M-extension ops.
- Output handshake and payload map 1:1 onto the MUL/DIV unit's request inputs.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- NUM_THREADS, 4: lanes per request.
- XLEN, 32: operand width (32 or 64).
- NUM_WARPS, 4: warps; NW_W = max(1, clog2(NUM_WARPS)).
- UUID_W, 44: instruction UUID width.
- NR_BITS, 6: destination register index width.
- OP_W, 4: M-extension opcode width.
- MOD_W, 3: op modifier width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  request valid.
- ready_in  out  1  queue can accept.
- alu_op_in  in  OP_W  M opcode.
- op_mod_in  in  MOD_W  modifier (W-form flag).
- uuid_in  in  UUID_W  instruction UUID.
- wid_in  in  NW_W  warp id.
- tmask_in  in  NUM_THREADS  thread mask.
- PC_in  in  XLEN  PC.
- rd_in  in  NR_BITS  destination register.
- wb_in  in  1  writeback enable.
- alu_in1_in  in  NUM_THREADS*XLEN  operand A per lane.
- alu_in2_in  in  NUM_THREADS*XLEN  operand B per lane.
- valid_out  out  1  head entry valid.
- ready_out  in  1  MUL/DIV unit accepts.
- alu_op_out … alu_in2_out  out  (same widths as the _in fields)  head entry payload.
- pending_wids  out  NUM_WARPS  bit w set while any queued entry has wid == w.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - head, tail, count and all per-warp counters clear to 0.
  - valid_out = 0, pending_wids = 0, empty = 1, full = 0.
  - Payload storage is not reset; *_out are don't-care while valid_out = 0.
  - A reset asserted mid-operation discards all queued entries. Any handshake in that cycle is ignored.
- Handshake:
  - enq = valid_in && ready_in.
  - deq = valid_out && ready_out.
  - ready_in = ~full. It does not depend on ready_out, so there is no combinational path from ready_out to ready_in.
  - valid_out = ~empty.
- Storage:
  - DEPTH-entry circular buffer; head/tail pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is clog2(DEPTH)+1 bits.
  - On enq, write the entry at tail, then tail++.
  - On deq, head++.
  - count += enq - deq.
- Output:
  - *_out reflect the entry at head combinationally from registered storage (first-word fall-through).
  - Latency: a request enqueued in cycle N is presented at the output in cycle N+1. There is no same-cycle bypass.
- Simultaneous events:
  - enq && deq when 0 < count < DEPTH: count unchanged, both pointers advance.
  - When full, ready_in = 0 even if deq fires in the same cycle; space appears the following cycle.
  - When empty, deq cannot occur (valid_out = 0).
- Stability: while valid_out && ~ready_out, the head entry and valid_out must not change.
- Per-warp counters:
  - pend_cnt[w] is clog2(DEPTH)+1 bits.
  - Increment on enq with wid_in == w; decrement on deq with wid_out == w.
  - Same warp on both in one cycle: counter unchanged.
  - pending_wids[w] = (pend_cnt[w] != 0), taken from registered counters, so it updates one cycle after the event.
- No payload transformation: the queue never inspects operands or opcode, and W-form sign extension remains the MUL/DIV unit's job.
- Assertions (sim only):
  - no enq when full;
  - no deq when empty;
  - count equals the sum of pend_cnt;
  - payload stable under stall.

Decomposition:
- Shared package holds:
  - the muldiv request struct: alu_op, op_mod, uuid, wid, tmask, PC, rd, wb, alu_in1[], alu_in2[];
  - REQ_W, its packed width;
  - OP_W and MOD_W constants.
- Natural sub-module: muldiv_fifo_core, a generic DEPTH x REQ_W circular buffer with pointers, count, full and empty.
- The per-warp counter array and the port packing/unpacking live in the top level.

Test Plan:
- Single request: enq wid=2, alu_op=MUL, alu_in1=7, alu_in2=6 with ready_out=1 → valid_out rises the next cycle with identical payload. pending_wids goes 0100 → 0000 one cycle after deq.
- Fill and backpressure: ready_out=0, 5 requests offered at DEPTH=4 → 4 accepted, full=1, ready_in=0, and the 5th is held. Raise ready_out → outputs drain in order by uuid 0..3, then the 5th enqueues.
- Simultaneous enq/deq at count=2: count stays 2, both pointers advance. After 10 cycles of continuous flow, uuids exit in order 0..9 across pointer wrap.
- Stall stability: valid_out=1, ready_out=0 for 8 cycles while new requests arrive → head payload and valid_out are constant, and count saturates at 4.
- Per-warp tracking: enq wids 1,1,3 then deq one wid=1 → pending_wids = 1010. After the remaining deqs, pending_wids = 0000.
- Mid-operation reset: 3 entries queued, reset=0 for 1 cycle with valid_in=1 → next cycle count=0, valid_out=0, pending_wids=0, empty=1, and the request offered during reset is not stored.

Source files
------------

// File: rtl/muldiv_dispatch_queue_pkg.sv
// muldiv_dispatch_queue_pkg: shared request layout, opcode encodings and width helper for the MUL/DIV dispatch queue
package muldiv_dispatch_queue_pkg;
  localparam int OP_W = 4;
  localparam int MOD_W = 3;
  localparam int P_NUM_THREADS = 4;
  localparam int P_XLEN = 32;
  localparam int P_NW_W = 2;
  localparam int P_UUID_W = 44;
  localparam int P_NR_BITS = 6;
  typedef enum logic [OP_W-1:0] {
    MUL = 4'd0, MULH = 4'd1, MULHSU = 4'd2, MULHU = 4'd3,
    DIV = 4'd4, DIVU = 4'd5, REM = 4'd6, REMU = 4'd7
  } muldiv_op_e;
  typedef struct packed {
    logic [OP_W-1:0] alu_op;
    logic [MOD_W-1:0] op_mod;
    logic [P_UUID_W-1:0] uuid;
    logic [P_NW_W-1:0] wid;
    logic [P_NUM_THREADS-1:0] tmask;
    logic [P_XLEN-1:0] PC;
    logic [P_NR_BITS-1:0] rd;
    logic wb;
    logic [P_NUM_THREADS-1:0][P_XLEN-1:0] alu_in1;
    logic [P_NUM_THREADS-1:0][P_XLEN-1:0] alu_in2;
  } muldiv_req_t;
  localparam int REQ_W = $bits(muldiv_req_t);
  function automatic int req_width(input int nt, input int xlen, input int nw_w, input int uuid_w, input int nr_bits);
    return OP_W + MOD_W + uuid_w + nw_w + nt + xlen + nr_bits + 1 + 2 * nt * xlen;
  endfunction
endpackage

// File: rtl/muldiv_dispatch_queue_fifo_core.sv
// muldiv_fifo_core: DEPTH x W circular buffer with first-word fall-through output, count, full and empty
module muldiv_fifo_core #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    head_q <= reset ? head_d : '0;
    tail_q <= reset ? tail_d : '0;
    count_q <= reset ? count_d : '0;
  end
  always_ff @(posedge clk)
    if (push) mem_q[tail_q] <= din;
  assign dout = mem_q[head_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/muldiv_dispatch_queue.sv
// muldiv_dispatch_queue: in-order request FIFO in front of the MUL/DIV unit with per-warp pending tracking
module muldiv_dispatch_queue
  import muldiv_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN = 32,
  parameter int NUM_WARPS = 4,
  parameter int UUID_W = 44,
  parameter int NR_BITS = 6,
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [OP_W-1:0]             alu_op_in,
  input  logic [MOD_W-1:0]            op_mod_in,
  input  logic [UUID_W-1:0]           uuid_in,
  input  logic [NW_W-1:0]             wid_in,
  input  logic [NUM_THREADS-1:0]      tmask_in,
  input  logic [XLEN-1:0]             PC_in,
  input  logic [NR_BITS-1:0]          rd_in,
  input  logic                        wb_in,
  input  logic [NUM_THREADS*XLEN-1:0] alu_in1_in,
  input  logic [NUM_THREADS*XLEN-1:0] alu_in2_in,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [OP_W-1:0]             alu_op_out,
  output logic [MOD_W-1:0]            op_mod_out,
  output logic [UUID_W-1:0]           uuid_out,
  output logic [NW_W-1:0]             wid_out,
  output logic [NUM_THREADS-1:0]      tmask_out,
  output logic [XLEN-1:0]             PC_out,
  output logic [NR_BITS-1:0]          rd_out,
  output logic                        wb_out,
  output logic [NUM_THREADS*XLEN-1:0] alu_in1_out,
  output logic [NUM_THREADS*XLEN-1:0] alu_in2_out,
  output logic [NUM_WARPS-1:0]        pending_wids,
  output logic                        empty,
  output logic                        full
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = req_width(NUM_THREADS, XLEN, NW_W, UUID_W, NR_BITS);
  logic enq, deq;
  logic [CW-1:0] count;
  logic [RW-1:0] din, dout;
  logic [CW-1:0] pend_cnt_q [NUM_WARPS];
  logic [CW-1:0] pend_cnt_d [NUM_WARPS];
  assign ready_in = ~full;
  assign valid_out = ~empty;
  assign enq = valid_in && ready_in;
  assign deq = valid_out && ready_out;
  assign din = {alu_op_in, op_mod_in, uuid_in, wid_in, tmask_in, PC_in, rd_in, wb_in, alu_in1_in, alu_in2_in};
  assign {alu_op_out, op_mod_out, uuid_out, wid_out, tmask_out, PC_out, rd_out, wb_out, alu_in1_out, alu_in2_out} = dout;
  muldiv_fifo_core #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(enq),
    .pop(deq),
    .din(din),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      pend_cnt_d[w] = pend_cnt_q[w] + CW'(enq && wid_in == NW_W'(w)) - CW'(deq && wid_out == NW_W'(w));
      pending_wids[w] = pend_cnt_q[w] != '0;
    end
  end
  always_ff @(posedge clk)
    for (int w = 0; w < NUM_WARPS; w++) pend_cnt_q[w] <= reset ? pend_cnt_d[w] : '0;
`ifndef SYNTHESIS
  logic stall_q;
  logic [RW-1:0] head_prev_q;
  int pend_sum;
  always_comb begin
    pend_sum = 0;
    for (int w = 0; w < NUM_WARPS; w++) pend_sum = pend_sum + int'(pend_cnt_q[w]);
  end
  always_ff @(posedge clk) begin
    stall_q <= reset && valid_out && !ready_out;
    head_prev_q <= dout;
    if (reset) begin
      assert (!(enq && full)) else $error("enqueue accepted while full");
      assert (!(deq && empty)) else $error("dequeue while empty");
      assert (pend_sum == int'(count)) else $error("pending counters %0d disagree with count %0d", pend_sum, count);
      if (stall_q) assert (valid_out && dout == head_prev_q) else $error("head entry changed under stall");
    end
  end
`endif
endmodule

// File: tb/tb_muldiv_dispatch_queue.sv
// tb_muldiv_dispatch_queue: directed and random stimulus checked against a queue-based reference model
module tb_muldiv_dispatch_queue;
  import muldiv_dispatch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, valid_in = 0, ready_out = 0;
  logic ready_in, valid_out, empty, full;
  logic [OP_W-1:0] alu_op_in, alu_op_out;
  logic [MOD_W-1:0] op_mod_in, op_mod_out;
  logic [P_UUID_W-1:0] uuid_in, uuid_out;
  logic [P_NW_W-1:0] wid_in, wid_out;
  logic [P_NUM_THREADS-1:0] tmask_in, tmask_out;
  logic [P_XLEN-1:0] PC_in, PC_out;
  logic [P_NR_BITS-1:0] rd_in, rd_out;
  logic wb_in, wb_out;
  logic [P_NUM_THREADS*P_XLEN-1:0] alu_in1_in, alu_in2_in, alu_in1_out, alu_in2_out;
  logic [3:0] pending_wids;
  muldiv_req_t cur, obs;
  muldiv_req_t q[$];
  int checks = 0, errors = 0;
  logic last_en;
  logic [P_UUID_W-1:0] uid = '0;
  always #5 clk = ~clk;
  assign {alu_op_in, op_mod_in, uuid_in, wid_in, tmask_in, PC_in, rd_in, wb_in, alu_in1_in, alu_in2_in} = cur;
  assign obs = {alu_op_out, op_mod_out, uuid_out, wid_out, tmask_out, PC_out, rd_out, wb_out, alu_in1_out, alu_in2_out};
  muldiv_dispatch_queue dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .alu_op_in(alu_op_in), .op_mod_in(op_mod_in), .uuid_in(uuid_in), .wid_in(wid_in),
    .tmask_in(tmask_in), .PC_in(PC_in), .rd_in(rd_in), .wb_in(wb_in),
    .alu_in1_in(alu_in1_in), .alu_in2_in(alu_in2_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .alu_op_out(alu_op_out), .op_mod_out(op_mod_out), .uuid_out(uuid_out), .wid_out(wid_out),
    .tmask_out(tmask_out), .PC_out(PC_out), .rd_out(rd_out), .wb_out(wb_out),
    .alu_in1_out(alu_in1_out), .alu_in2_out(alu_in2_out),
    .pending_wids(pending_wids), .empty(empty), .full(full)
  );
  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin errors++; $error("FAIL %s observed=%b expected=%b", tag, o, e); end
  endtask
  task automatic chk4(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin errors++; $error("FAIL %s observed=%b expected=%b", tag, o, e); end
  endtask
  task automatic chk_req(input string tag, input muldiv_req_t o, input muldiv_req_t e);
    checks++;
    assert (o === e) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, o, e); end
  endtask
  task automatic new_req(input int w);
    cur.alu_op = OP_W'($urandom_range(0, 7));
    cur.op_mod = MOD_W'($urandom);
    cur.uuid = uid;
    uid++;
    cur.wid = (w < 0) ? P_NW_W'($urandom) : P_NW_W'(w);
    cur.tmask = P_NUM_THREADS'($urandom);
    cur.PC = $urandom;
    cur.rd = P_NR_BITS'($urandom);
    cur.wb = 1'($urandom);
    for (int i = 0; i < P_NUM_THREADS; i++) begin
      cur.alu_in1[i] = $urandom;
      cur.alu_in2[i] = $urandom;
    end
  endtask
  task automatic step();
    logic [3:0] pw;
    logic de;
    @(negedge clk);
    pw = '0;
    foreach (q[i]) pw[q[i].wid] = 1'b1;
    chk1("valid_out", valid_out, q.size() != 0);
    chk1("ready_in", ready_in, q.size() != DEPTH);
    chk1("empty", empty, q.size() == 0);
    chk1("full", full, q.size() == DEPTH);
    chk4("pending_wids", pending_wids, pw);
    if (q.size() != 0) chk_req("head_payload", obs, q[0]);
    last_en = reset && valid_in && q.size() < DEPTH;
    de = reset && ready_out && q.size() != 0;
    @(posedge clk);
    if (!reset) q.delete();
    else begin
      if (de) void'(q.pop_front());
      if (last_en) q.push_back(cur);
    end
    #1;
  endtask
  task automatic offer(input int n);
    repeat (n) begin
      step();
      if (last_en) new_req(-1);
    end
  endtask
  initial begin
    new_req(0);
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1;
    uid = '0;
    new_req(2);
    cur.alu_op = MUL;
    for (int i = 0; i < P_NUM_THREADS; i++) begin
      cur.alu_in1[i] = 7;
      cur.alu_in2[i] = 6;
    end
    ready_out = 1;
    valid_in = 1;
    step();
    valid_in = 0;
    repeat (3) step();
    uid = '0;
    new_req(-1);
    ready_out = 0;
    valid_in = 1;
    offer(6);
    ready_out = 1;
    offer(6);
    valid_in = 0;
    repeat (6) step();
    uid = '0;
    new_req(-1);
    ready_out = 0;
    valid_in = 1;
    offer(2);
    ready_out = 1;
    offer(10);
    valid_in = 0;
    repeat (4) step();
    new_req(-1);
    ready_out = 0;
    valid_in = 1;
    offer(9);
    ready_out = 1;
    valid_in = 0;
    repeat (6) step();
    ready_out = 0;
    valid_in = 1;
    new_req(1);
    step();
    new_req(1);
    step();
    new_req(3);
    step();
    valid_in = 0;
    ready_out = 1;
    step();
    ready_out = 0;
    step();
    ready_out = 1;
    repeat (4) step();
    ready_out = 0;
    valid_in = 1;
    repeat (3) begin
      new_req(-1);
      step();
    end
    new_req(-1);
    reset = 0;
    step();
    reset = 1;
    valid_in = 0;
    repeat (2) step();
    new_req(-1);
    repeat (400) begin
      valid_in = 1'($urandom_range(0, 1));
      ready_out = 1'($urandom_range(0, 1));
      reset = $urandom_range(0, 49) != 0;
      step();
      if (last_en) new_req(-1);
    end
    reset = 1;
    valid_in = 0;
    ready_out = 1;
    repeat (6) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
